vtx_mem_txn_tracker: RTL and testbench

//  Sequences capture of per-instruction memory transactions for the formal

---
 rtl/vtx_mem_txn_tracker.sv | 156 +++++++++++++++
 tb/tb_vtx_mem_txn_tracker.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vtx_mem_txn_tracker.sv
// Per-instruction memory transaction tracker for formal trace export.
// Captures up to NTXN requests/responses, waits for retire and drain, then emits one record.
module vtx_mem_txn_tracker #(
    parameter int NTXN  = 4,
    parameter int CNT_W = 3
) (
    input  logic                vtx_clk,
    input  logic                vtx_reset,
    input  logic                mem_cen,
    input  logic                mem_stall,
    input  logic                mem_wen,
    input  logic [31:0]         mem_addr,
    input  logic [31:0]         mem_wdata,
    input  logic [3:0]          mem_ben,
    input  logic                mem_rsp_valid,
    input  logic [31:0]         mem_rdata,
    input  logic                mem_error,
    input  logic                cop_retire,
    input  logic [31:0]         cop_instr_enc,
    output logic                trk_hold,
    output logic                vtx_valid,
    output logic [31:0]         vtx_instr_enc,
    output logic [NTXN-1:0]     vtx_mem_cen,
    output logic [NTXN-1:0]     vtx_mem_wen,
    output logic [32*NTXN-1:0]  vtx_mem_addr,
    output logic [32*NTXN-1:0]  vtx_mem_wdata,
    output logic [32*NTXN-1:0]  vtx_mem_rdata,
    output logic [4*NTXN-1:0]   vtx_mem_ben,
    output logic [NTXN-1:0]     vtx_mem_error,
    output logic                vtx_mem_ovf,
    output logic                vtx_rsp_err
);

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        DRAIN   = 2'd1,
        EMIT    = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] NTXN_C = CNT_W'(NTXN);
    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] req_ptr;
    logic [CNT_W-1:0] rsp_ptr;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] outstanding_next;
    logic             accept;
    logic             rsp_ok;
    logic             rsp_spur;

    assign trk_hold  = (state != COLLECT);
    assign vtx_valid = (state == EMIT);

    // A response with nothing outstanding is only flagged while collecting; EMIT ignores all traffic.
    always_comb begin
        accept           = mem_cen && !mem_stall && !trk_hold;
        rsp_ok           = mem_rsp_valid && (outstanding != '0) && (state != EMIT);
        rsp_spur         = mem_rsp_valid && (outstanding == '0) && (state == COLLECT);
        outstanding_next = outstanding + CNT_W'(accept) - CNT_W'(rsp_ok);
    end

    always_ff @(posedge vtx_clk or posedge vtx_reset) begin
        if (vtx_reset) begin
            state <= COLLECT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            COLLECT: begin
                if (cop_retire) begin
                    state_next = (outstanding_next == '0) ? EMIT : DRAIN;
                end
            end
            DRAIN: begin
                if (rsp_ok && (outstanding == ONE)) begin
                    state_next = EMIT;
                end
            end
            EMIT:    state_next = COLLECT;
            default: state_next = COLLECT;
        endcase
    end

    // Slot capture; the record is held untouched through EMIT and wiped on the way out.
    always_ff @(posedge vtx_clk or posedge vtx_reset) begin
        if (vtx_reset) begin
            req_ptr       <= '0;
            rsp_ptr       <= '0;
            outstanding   <= '0;
            vtx_instr_enc <= '0;
            vtx_mem_cen   <= '0;
            vtx_mem_wen   <= '0;
            vtx_mem_addr  <= '0;
            vtx_mem_wdata <= '0;
            vtx_mem_rdata <= '0;
            vtx_mem_ben   <= '0;
            vtx_mem_error <= '0;
            vtx_mem_ovf   <= 1'b0;
            vtx_rsp_err   <= 1'b0;
        end else if (state == EMIT) begin
            req_ptr       <= '0;
            rsp_ptr       <= '0;
            outstanding   <= '0;
            vtx_mem_cen   <= '0;
            vtx_mem_wen   <= '0;
            vtx_mem_addr  <= '0;
            vtx_mem_wdata <= '0;
            vtx_mem_rdata <= '0;
            vtx_mem_ben   <= '0;
            vtx_mem_error <= '0;
            vtx_mem_ovf   <= 1'b0;
            vtx_rsp_err   <= 1'b0;
        end else begin
            outstanding <= outstanding_next;
            if (cop_retire && (state == COLLECT)) begin
                vtx_instr_enc <= cop_instr_enc;
            end
            if (rsp_spur) begin
                vtx_rsp_err <= 1'b1;
            end
            if (accept) begin
                if (req_ptr < NTXN_C) begin
                    for (int i = 0; i < NTXN; i++) begin
                        if (req_ptr == CNT_W'(i)) begin
                            vtx_mem_cen[i]             <= 1'b1;
                            vtx_mem_wen[i]             <= mem_wen;
                            vtx_mem_addr[32*i +: 32]   <= mem_addr;
                            vtx_mem_wdata[32*i +: 32]  <= mem_wdata;
                            vtx_mem_ben[4*i +: 4]      <= mem_ben;
                        end
                    end
                    req_ptr <= req_ptr + ONE;
                end else begin
                    vtx_mem_ovf <= 1'b1;
                end
            end
            // Responses past the last slot still retire an outstanding request; the pointer saturates.
            if (rsp_ok && (rsp_ptr < NTXN_C)) begin
                for (int i = 0; i < NTXN; i++) begin
                    if (rsp_ptr == CNT_W'(i)) begin
                        vtx_mem_rdata[32*i +: 32] <= vtx_mem_wen[i] ? 32'h0 : mem_rdata;
                        vtx_mem_error[i]          <= mem_error;
                    end
                end
                rsp_ptr <= rsp_ptr + ONE;
            end
        end
    end

endmodule

// File: tb/tb_vtx_mem_txn_tracker.sv
// Directed and randomized bench for vtx_mem_txn_tracker against a transaction-list reference model.
module tb_vtx_mem_txn_tracker;

    logic         vtx_clk = 1'b0;
    logic         vtx_reset;
    logic         mem_cen, mem_stall, mem_wen, mem_rsp_valid, mem_error, cop_retire;
    logic [31:0]  mem_addr, mem_wdata, mem_rdata, cop_instr_enc;
    logic [3:0]   mem_ben;
    logic         trk_hold, vtx_valid, vtx_mem_ovf, vtx_rsp_err;
    logic [31:0]  vtx_instr_enc;
    logic [3:0]   vtx_mem_cen, vtx_mem_wen, vtx_mem_error;
    logic [127:0] vtx_mem_addr, vtx_mem_wdata, vtx_mem_rdata;
    logic [15:0]  vtx_mem_ben;

    vtx_mem_txn_tracker dut (
        .vtx_clk(vtx_clk), .vtx_reset(vtx_reset),
        .mem_cen(mem_cen), .mem_stall(mem_stall), .mem_wen(mem_wen),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ben(mem_ben),
        .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata), .mem_error(mem_error),
        .cop_retire(cop_retire), .cop_instr_enc(cop_instr_enc),
        .trk_hold(trk_hold), .vtx_valid(vtx_valid), .vtx_instr_enc(vtx_instr_enc),
        .vtx_mem_cen(vtx_mem_cen), .vtx_mem_wen(vtx_mem_wen), .vtx_mem_addr(vtx_mem_addr),
        .vtx_mem_wdata(vtx_mem_wdata), .vtx_mem_rdata(vtx_mem_rdata), .vtx_mem_ben(vtx_mem_ben),
        .vtx_mem_error(vtx_mem_error), .vtx_mem_ovf(vtx_mem_ovf), .vtx_rsp_err(vtx_rsp_err)
    );

    always #5 vtx_clk = ~vtx_clk;

    typedef struct {
        logic        wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  ben;
    } req_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    // Model: every accepted request and every matched response of the current instruction, in order.
    req_t        req_q[$];
    rsp_t        rsp_q[$];
    int          m_outst;
    int          m_phase;
    bit          m_spur;
    logic [31:0] m_enc;
    int          n_checks;
    int          n_fail;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic reset_model();
        req_q.delete();
        rsp_q.delete();
        m_outst = 0;
        m_phase = 0;
        m_spur  = 1'b0;
        m_enc   = '0;
    endtask

    task automatic clear_inputs();
        mem_cen = 0; mem_stall = 0; mem_wen = 0; mem_addr = '0; mem_wdata = '0; mem_ben = '0;
        mem_rsp_valid = 0; mem_rdata = '0; mem_error = 0; cop_retire = 0; cop_instr_enc = '0;
    endtask

    task automatic check_record();
        logic [3:0]   e_cen, e_wen, e_err;
        logic [127:0] e_addr, e_wdata, e_rdata;
        logic [15:0]  e_ben;
        e_cen = '0; e_wen = '0; e_err = '0; e_addr = '0; e_wdata = '0; e_rdata = '0; e_ben = '0;
        for (int i = 0; i < 4; i++) begin
            if (i < req_q.size()) begin
                e_cen[i]            = 1'b1;
                e_wen[i]            = req_q[i].wen;
                e_addr[32*i +: 32]  = req_q[i].addr;
                e_wdata[32*i +: 32] = req_q[i].wdata;
                e_ben[4*i +: 4]     = req_q[i].ben;
                if (i < rsp_q.size()) begin
                    e_rdata[32*i +: 32] = req_q[i].wen ? 32'h0 : rsp_q[i].rdata;
                    e_err[i]            = rsp_q[i].err;
                end
            end
        end
        check("rec_cen", vtx_mem_cen, e_cen);
        check("rec_wen", vtx_mem_wen, e_wen);
        check("rec_addr", vtx_mem_addr, e_addr);
        check("rec_wdata", vtx_mem_wdata, e_wdata);
        check("rec_rdata", vtx_mem_rdata, e_rdata);
        check("rec_ben", vtx_mem_ben, e_ben);
        check("rec_err", vtx_mem_error, e_err);
        check("rec_ovf", vtx_mem_ovf, req_q.size() > 4);
        check("rec_rsp_err", vtx_rsp_err, m_spur);
        check("rec_enc", vtx_instr_enc, m_enc);
    endtask

    // One clock: update the model from the driven inputs, clock, then compare just after the edge.
    task automatic apply_stimulus();
        bit acc, good;
        acc  = mem_cen && !mem_stall && (m_phase == 0);
        good = mem_rsp_valid && (m_outst > 0) && (m_phase != 2);
        if (m_phase == 2) begin
            m_phase = 0;
            req_q.delete();
            rsp_q.delete();
            m_spur = 1'b0;
        end else begin
            if (acc) req_q.push_back('{mem_wen, mem_addr, mem_wdata, mem_ben});
            if (good) rsp_q.push_back('{mem_rdata, mem_error});
            if (mem_rsp_valid && m_outst == 0 && m_phase == 0) m_spur = 1'b1;
            m_outst = m_outst + int'(acc) - int'(good);
            if (m_phase == 0 && cop_retire) begin
                m_enc   = cop_instr_enc;
                m_phase = (m_outst == 0) ? 2 : 1;
            end else if (m_phase == 1 && good && m_outst == 0) begin
                m_phase = 2;
            end
        end
        @(posedge vtx_clk);
        #1;
        check_output();
    endtask

    task automatic check_output();
        check("trk_hold", trk_hold, m_phase != 0);
        check("vtx_valid", vtx_valid, m_phase == 2);
        if (m_phase == 2) check_record();
    endtask

    task automatic idle();
        clear_inputs();
        apply_stimulus();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, vtx_valid, 1'b0);
        check({tag, "_hold"}, trk_hold, 1'b0);
        check({tag, "_cen"}, vtx_mem_cen, 4'b0);
        check({tag, "_addr"}, vtx_mem_addr, 128'h0);
        check({tag, "_enc"}, vtx_instr_enc, 32'h0);
        check({tag, "_ovf"}, vtx_mem_ovf, 1'b0);
        check({tag, "_rsp_err"}, vtx_rsp_err, 1'b0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset_model();
        clear_inputs();
        vtx_reset = 1'b1;
        #12;
        check_all_zero("reset");
        vtx_reset = 1'b0;

        // Retire with no requests
        clear_inputs();
        cop_retire = 1; cop_instr_enc = 32'h0000_600B;
        apply_stimulus();
        check("t1_cen", vtx_mem_cen, 4'b0000);
        check("t1_enc", vtx_instr_enc, 32'h0000_600B);
        idle();
        check("t1_valid_drop", vtx_valid, 1'b0);

        // Load, retire while outstanding, response two cycles after accept
        clear_inputs();
        mem_cen = 1; mem_addr = 32'h100; mem_ben = 4'hF;
        apply_stimulus();
        clear_inputs();
        cop_retire = 1; cop_instr_enc = 32'h0000_2003;
        apply_stimulus();
        check("t2_drain_hold", trk_hold, 1'b1);
        clear_inputs();
        mem_rsp_valid = 1; mem_rdata = 32'hDEAD_BEEF;
        apply_stimulus();
        check("t2_valid", vtx_valid, 1'b1);
        check("t2_addr0", vtx_mem_addr[31:0], 32'h100);
        check("t2_rdata0", vtx_mem_rdata[31:0], 32'hDEAD_BEEF);
        check("t2_cen", vtx_mem_cen, 4'b0001);
        idle();

        // Five writes, overflow; final retire coincides with the last response
        for (int i = 0; i < 5; i++) begin
            clear_inputs();
            mem_cen = 1; mem_wen = 1; mem_ben = 4'hF;
            mem_addr = 32'h2000 + 32'(i * 4); mem_wdata = 32'hA000 + 32'(i);
            mem_rsp_valid = (i > 0); mem_rdata = 32'h5555_0000 + 32'(i);
            apply_stimulus();
        end
        clear_inputs();
        cop_retire = 1; cop_instr_enc = 32'h0000_0023; mem_rsp_valid = 1;
        apply_stimulus();
        check("t3_cen", vtx_mem_cen, 4'b1111);
        check("t3_ovf", vtx_mem_ovf, 1'b1);
        check("t3_addr", vtx_mem_addr, {32'h200C, 32'h2008, 32'h2004, 32'h2000});
        check("t3_rdata", vtx_mem_rdata, 128'h0);
        idle();

        // Stalled request captured once
        for (int i = 0; i < 4; i++) begin
            clear_inputs();
            mem_cen = 1; mem_stall = (i < 3); mem_addr = 32'h300; mem_ben = 4'h3;
            apply_stimulus();
        end
        clear_inputs();
        cop_retire = 1; cop_instr_enc = 32'h1;
        apply_stimulus();
        clear_inputs();
        mem_rsp_valid = 1; mem_rdata = 32'h1234_5678; mem_error = 1;
        apply_stimulus();
        check("t4_cen", vtx_mem_cen, 4'b0001);
        check("t4_err", vtx_mem_error, 4'b0001);
        idle();

        // Spurious response
        clear_inputs();
        mem_rsp_valid = 1; mem_rdata = 32'hBAD;
        apply_stimulus();
        clear_inputs();
        cop_retire = 1; cop_instr_enc = 32'h2;
        apply_stimulus();
        check("t5_rsp_err", vtx_rsp_err, 1'b1);
        check("t5_cen", vtx_mem_cen, 4'b0000);
        idle();

        // Asynchronous reset while draining
        clear_inputs();
        mem_cen = 1; mem_addr = 32'h400; mem_ben = 4'h1;
        apply_stimulus();
        clear_inputs();
        cop_retire = 1; cop_instr_enc = 32'h3;
        apply_stimulus();
        check("t6_in_drain", trk_hold, 1'b1);
        #3;
        vtx_reset = 1'b1;
        #1;
        check_all_zero("t6_reset");
        vtx_reset = 1'b0;
        reset_model();
        clear_inputs();
        cop_retire = 1; cop_instr_enc = 32'h4;
        apply_stimulus();
        check("t6_retire_ok", vtx_valid, 1'b1);
        idle();

        // Randomized instructions
        for (int n = 0; n < 40; n++) begin
            int  nreq;
            int  nacc;
            bit  done;
            nreq = int'($urandom_range(0, 6));
            nacc = 0;
            done = 1'b0;
            for (int c = 0; c < 200 && !done; c++) begin
                clear_inputs();
                mem_cen   = (m_phase == 0) && (nacc < nreq) && ($urandom % 3 != 0);
                mem_stall = ($urandom % 4 == 0);
                mem_wen   = $urandom % 2;
                mem_addr  = $urandom;
                mem_wdata = $urandom;
                mem_ben   = 4'($urandom);
                mem_rdata = $urandom;
                mem_error = ($urandom % 5 == 0);
                mem_rsp_valid = (m_outst > 0) ? ($urandom % 2 == 1) : ((m_phase == 0) && ($urandom % 16 == 0));
                if (mem_cen && !mem_stall) nacc++;
                cop_retire    = (m_phase == 0) && (nacc >= nreq) && ($urandom % 2 == 1);
                cop_instr_enc = $urandom;
                apply_stimulus();
                if (m_phase == 2) done = 1'b1;
            end
            check("rand_emit_seen", done, 1'b1);
            idle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
